jogo_memoria_param: RTL and testbench

- Parametrised successor of the sequence-memory game datapath+control: the player repeats a growing sequence of button presses, one extra play per round.
- Adds configurable button count, round count and timeout, plus a new SHOW phase that replays the sequence on the LEDs before each round.
- Adds a distinct timeout-loss indication.
- Sits at the top of the game design; buttons come from board inputs, LEDs and status drive the board.

---
 rtl/jogo_memoria_param.sv | 153 +++++++++++++++
 tb/tb_jogo_memoria_param.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/jogo_memoria_param.sv
// Sequence-memory game: replays a growing one-hot sequence on the LEDs, then
// checks the player's presses against it, with a per-play timeout.
module jogo_memoria_param #(
  parameter int N_BOTOES  = 4,
  parameter int N_RODADAS = 16,
  parameter int TIMEOUT   = 5000,
  parameter int T_MOSTRA  = 1000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic [N_BOTOES-1:0] botoes,
  output logic [N_BOTOES-1:0] leds,
  output logic                pronto,
  output logic                ganhou,
  output logic                perdeu,
  output logic                db_timeout,
  output logic                db_igual,
  output logic [3:0]          db_estado,
  output logic [5:0]          db_rodada,
  output logic [5:0]          db_contagem
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int SW = (T_MOSTRA > 1) ? $clog2(T_MOSTRA) : 1;

  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    PREPARA     = 4'd1,
    MOSTRA_ON   = 4'd2,
    MOSTRA_OFF  = 4'd3,
    ESPERA      = 4'd4,
    COMPARA     = 4'd5,
    FIM_RODADA  = 4'd6,
    FIM_GANHOU  = 4'd7,
    FIM_PERDEU  = 4'd8,
    FIM_TIMEOUT = 4'd9
  } estado_t;

  estado_t             estado;
  logic [5:0]          rodada;
  logic [5:0]          contagem;
  logic [TW-1:0]       tmr;
  logic [SW-1:0]       shw;
  logic [N_BOTOES-1:0] jogada_reg;
  logic                prev_or;
  logic                igual;
  logic                jogada;
  logic [N_BOTOES-1:0] esperado;

  // A play is only the rising edge of "any button"; a held button never re-triggers.
  assign jogada   = (|botoes) & ~prev_or;
  assign esperado = {{(N_BOTOES-1){1'b0}}, 1'b1} << (contagem % 6'(N_BOTOES));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado     <= INICIAL;
      rodada     <= '0;
      contagem   <= '0;
      tmr        <= '0;
      shw        <= '0;
      jogada_reg <= '0;
      prev_or    <= 1'b0;
      igual      <= 1'b0;
    end else begin
      prev_or <= |botoes;
      case (estado)
        INICIAL: if (iniciar) estado <= PREPARA;
        PREPARA: begin
          rodada   <= '0;
          contagem <= '0;
          igual    <= 1'b0;
          shw      <= '0;
          estado   <= MOSTRA_ON;
        end
        MOSTRA_ON: begin
          if (shw == SW'(T_MOSTRA - 1)) begin
            shw    <= '0;
            estado <= MOSTRA_OFF;
          end else begin
            shw <= shw + 1'b1;
          end
        end
        MOSTRA_OFF: begin
          if (shw == SW'(T_MOSTRA - 1)) begin
            shw <= '0;
            if (contagem == rodada) begin
              contagem <= '0;
              tmr      <= '0;
              estado   <= ESPERA;
            end else begin
              contagem <= contagem + 6'd1;
              estado   <= MOSTRA_ON;
            end
          end else begin
            shw <= shw + 1'b1;
          end
        end
        ESPERA: begin
          // A press landing in the last timeout cycle still counts as a play.
          if (jogada) begin
            jogada_reg <= botoes;
            estado     <= COMPARA;
          end else if (tmr == TW'(TIMEOUT - 1)) begin
            estado <= FIM_TIMEOUT;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        COMPARA: begin
          igual <= (jogada_reg == esperado);
          if (jogada_reg != esperado) begin
            estado <= FIM_PERDEU;
          end else if (contagem < rodada) begin
            contagem <= contagem + 6'd1;
            tmr      <= '0;
            estado   <= ESPERA;
          end else begin
            estado <= FIM_RODADA;
          end
        end
        FIM_RODADA: begin
          if (rodada == 6'(N_RODADAS - 1)) begin
            estado <= FIM_GANHOU;
          end else begin
            rodada   <= rodada + 6'd1;
            contagem <= '0;
            shw      <= '0;
            estado   <= MOSTRA_ON;
          end
        end
        FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT: if (iniciar) estado <= PREPARA;
        default: estado <= INICIAL;
      endcase
    end
  end

  always_comb begin
    leds = botoes;
    if (estado == MOSTRA_ON)       leds = esperado;
    else if (estado == MOSTRA_OFF) leds = '0;
  end

  assign pronto      = (estado == FIM_GANHOU) || (estado == FIM_PERDEU) || (estado == FIM_TIMEOUT);
  assign ganhou      = (estado == FIM_GANHOU);
  assign perdeu      = (estado == FIM_PERDEU) || (estado == FIM_TIMEOUT);
  assign db_timeout  = (estado == FIM_TIMEOUT);
  assign db_igual    = igual;
  assign db_estado   = estado;
  assign db_rodada   = rodada;
  assign db_contagem = contagem;

endmodule

// File: tb/tb_jogo_memoria_param.sv
// Directed bench for jogo_memoria_param with N_BOTOES=4, N_RODADAS=3,
// TIMEOUT=20, T_MOSTRA=3; inputs change and outputs are sampled 1ns after posedge.
module tb_jogo_memoria_param;

  localparam int N = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic         iniciar;
  logic [N-1:0] botoes;
  logic [N-1:0] leds;
  logic         pronto, ganhou, perdeu, db_timeout, db_igual;
  logic [3:0]   db_estado;
  logic [5:0]   db_rodada, db_contagem;

  int n_checks = 0;
  int n_fail   = 0;

  jogo_memoria_param #(
    .N_BOTOES(4), .N_RODADAS(3), .TIMEOUT(20), .T_MOSTRA(3)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .botoes(botoes),
    .leds(leds), .pronto(pronto), .ganhou(ganhou), .perdeu(perdeu),
    .db_timeout(db_timeout), .db_igual(db_igual), .db_estado(db_estado),
    .db_rodada(db_rodada), .db_contagem(db_contagem)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_state(input string tag, input logic [3:0] s, input int budget);
    int k = 0;
    while (db_estado !== s && k < budget) begin
      tick();
      k++;
    end
    check(tag, db_estado, s);
  endtask

  task automatic press(input logic [N-1:0] b);
    botoes = b;
    tick();
    botoes = '0;
    tick();
  endtask

  task automatic play_round(input int r);
    wait_state("wait_espera", 4'd4, 100);
    for (int i = 0; i <= r; i++) press(N'(1) << (i % N));
  endtask

  task automatic restart();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
  endtask

  initial begin
    reset = 1'b1; iniciar = 1'b0; botoes = '0;
    tick(); tick();
    check("rst_estado", db_estado, 0);
    check("rst_leds", leds, 0);
    check("rst_flags", {pronto, ganhou, perdeu, db_timeout, db_igual}, 0);
    check("rst_rodada", db_rodada, 0);
    check("rst_contagem", db_contagem, 0);
    reset = 1'b0;
    tick();
    check("idle_estado", db_estado, 0);

    // 1: start and first show
    iniciar = 1'b1;
    tick();
    check("t1_prepara", db_estado, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("t1_on_estado", db_estado, 2);
      check("t1_on_leds", leds, 4'b0001);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      check("t1_off_estado", db_estado, 3);
      check("t1_off_leds", leds, 0);
      tick();
    end
    check("t1_espera", db_estado, 4);
    iniciar = 1'b0;

    // 2: full correct game
    press(4'b0001);
    wait_state("t2_r1_on0", 4'd2, 20);
    check("t2_r1_leds0", leds, 4'b0001);
    check("t2_r1_rodada", db_rodada, 1);
    wait_state("t2_r1_off0", 4'd3, 20);
    wait_state("t2_r1_on1", 4'd2, 20);
    check("t2_r1_leds1", leds, 4'b0010);
    check("t2_r1_cont1", db_contagem, 1);
    play_round(1);
    play_round(2);
    wait_state("t2_ganhou_st", 4'd7, 20);
    check("t2_ganhou", ganhou, 1);
    check("t2_pronto", pronto, 1);
    check("t2_perdeu", perdeu, 0);
    check("t2_rodada", db_rodada, 2);
    check("t2_igual", db_igual, 1);

    // 3: wrong second play in round 1
    restart();
    check("t3_prepara", db_estado, 1);
    play_round(0);
    wait_state("t3_espera", 4'd4, 100);
    press(4'b0001);
    botoes = 4'b0100;
    tick();
    check("t3_compara", db_estado, 5);
    check("t3_perdeu_early", perdeu, 0);
    botoes = '0;
    tick();
    check("t3_estado", db_estado, 8);
    check("t3_perdeu", perdeu, 1);
    check("t3_timeout", db_timeout, 0);
    check("t3_igual", db_igual, 0);
    check("t3_contagem", db_contagem, 1);

    // 4: timeout in round 0
    restart();
    wait_state("t4_espera", 4'd4, 100);
    for (int i = 0; i < 19; i++) tick();
    check("t4_last_wait", db_estado, 4);
    tick();
    check("t4_estado", db_estado, 9);
    check("t4_perdeu", perdeu, 1);
    check("t4_timeout", db_timeout, 1);
    check("t4_pronto", pronto, 1);
    check("t4_ganhou", ganhou, 0);

    // 5a: two buttons at once
    restart();
    wait_state("t5_espera", 4'd4, 100);
    press(4'b0011);
    check("t5_double", db_estado, 8);
    check("t5_igual", db_igual, 0);

    // 5b: button held from show into wait is not a play
    restart();
    wait_state("t5b_on", 4'd2, 20);
    botoes = 4'b0001;
    wait_state("t5b_espera", 4'd4, 100);
    for (int i = 0; i < 5; i++) tick();
    check("t5b_held", db_estado, 4);
    check("t5b_echo", leds, 4'b0001);
    botoes = '0;
    tick();
    press(4'b0001);
    check("t5b_repress", db_estado, 6);

    // 6: reset in the middle of round 1 show
    wait_state("t6_on", 4'd2, 20);
    check("t6_rodada1", db_rodada, 1);
    #1 reset = 1'b1;
    #1;
    check("t6_rst_estado", db_estado, 0);
    check("t6_rst_leds", leds, 0);
    check("t6_rst_rodada", db_rodada, 0);
    check("t6_rst_cont", db_contagem, 0);
    tick();
    reset = 1'b0;
    tick();
    restart();
    wait_state("t6_espera", 4'd4, 100);
    check("t6_rodada0", db_rodada, 0);
    press(4'b0010);
    check("t6_perdeu", db_estado, 8);
    restart();
    check("t6_restart", db_estado, 1);
    tick();
    check("t6_restart_on", db_estado, 2);
    check("t6_restart_rod", db_rodada, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
